// File: rtl/phase_ctrl.sv
// phase_ctrl: per-phase control-strobe generator for a 4-phase CPU.
// The CPU phases are fetch, decode, execute and store.
// The block latches the instruction register, decodes the register fields,
// drives the datapath strobes and counts retired instructions.
// Optional macro PHASE_CHECK_EN adds a phase-sequence checker. The checker
// suppresses strobes on an illegal phase and resyncs on the next fetch.
module phase_ctrl #(
    parameter int IW = 8,   // instruction width; field layout assumes exactly 8
    parameter int CW = 16   // retired-instruction counter width
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    phase,
    input  logic [IW-1:0] instr_in,
    input  logic          zero_in,
    output logic [IW-1:0] ir,
    output logic [1:0]    rd,
    output logic [1:0]    rs,
    output logic [1:0]    rt,
    output logic          ir_load,
    output logic          alu_en,
    output logic          mem_we,
    output logic          reg_we,
    output logic          pc_inc,
    output logic          pc_load,
    output logic [CW-1:0] retire_cnt,
    output logic          phase_err
);

    typedef enum logic [1:0] {
        PH_FETCH  = 2'b00,
        PH_DECODE = 2'b01,
        PH_EXEC   = 2'b10,
        PH_STORE  = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ALU   = 2'b01,
        OP_STORE = 2'b10,
        OP_BRZ   = 2'b11
    } op_t;

    logic [IW-1:0] ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_t           op;
    logic          in_seq;   // current phase is acceptable for the strobes
    logic          act;      // strobes enabled this cycle

    assign op         = op_t'(ir_q[7:6]);
    assign ir         = ir_q;
    assign rd         = ir_q[5:4];
    assign rs         = ir_q[3:2];
    assign rt         = ir_q[1:0];
    assign retire_cnt = cnt_q;

`ifdef PHASE_CHECK_EN
    phase_t exp_q, exp_d;
    logic   sync_q, sync_d;
    logic   err_q, err_d;

    // Compare the phase with the expected phase. A fetch resyncs when out of sync.
    // A mismatch while in sync drops sync and sets the sticky error flag.
    always_comb begin
        in_seq = sync_q ? (phase_t'(phase) == exp_q) : (phase_t'(phase) == PH_FETCH);
        sync_d = sync_q;
        exp_d  = exp_q;
        err_d  = err_q;
        if (in_seq) begin
            sync_d = 1'b1;
            exp_d  = phase_t'(phase + 2'd1);
        end else if (sync_q) begin
            sync_d = 1'b0;
            err_d  = 1'b1;
        end
    end

    // Checker registers. After reset the sequencer is expected to present a store phase first.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q  <= PH_STORE;
            sync_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            sync_q <= sync_d;
            err_q  <= err_d;
        end
    end

    assign phase_err = err_q;
`else
    assign in_seq    = 1'b1;
    assign phase_err = 1'b0;
`endif

    // Decode the phase and opcode into zero-latency strobes and the next IR and counter values.
    always_comb begin
        ir_load = 1'b0;
        alu_en  = 1'b0;
        mem_we  = 1'b0;
        reg_we  = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        act     = !reset && in_seq;
        if (act) begin
            unique case (phase_t'(phase))
                PH_FETCH: begin
                    ir_load = 1'b1;
                    ir_d    = instr_in;
                end
                PH_DECODE: ;
                PH_EXEC: begin
                    alu_en = (op == OP_ALU);
                    mem_we = (op == OP_STORE);
                end
                PH_STORE: begin
                    reg_we = (op == OP_ALU);
                    if (op == OP_BRZ && zero_in) pc_load = 1'b1;
                    else                         pc_inc  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            endcase
        end
    end

    // Instruction register and retirement counter. Reset loads a NOP and clears the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= '0;
            cnt_q <= '0;
        end else begin
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed plus randomized bench for phase_ctrl.
// The bench checks the block against an instruction-level reference model.
module tb_phase_ctrl;
    localparam int CW = 4;
`ifdef PHASE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    phase;
    logic [7:0]    instr_in;
    logic          zero_in;
    logic [7:0]    ir;
    logic [1:0]    rd, rs, rt;
    logic          ir_load, alu_en, mem_we, reg_we, pc_inc, pc_load;
    logic [CW-1:0] retire_cnt;
    logic          phase_err;

    always #5 clk = ~clk;

    phase_ctrl #(.IW(8), .CW(CW)) dut (
        .clk(clk), .reset(reset), .phase(phase), .instr_in(instr_in), .zero_in(zero_in),
        .ir(ir), .rd(rd), .rs(rs), .rt(rt),
        .ir_load(ir_load), .alu_en(alu_en), .mem_we(mem_we), .reg_we(reg_we),
        .pc_inc(pc_inc), .pc_load(pc_load), .retire_cnt(retire_cnt), .phase_err(phase_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [7:0] m_ir;
    int         m_cnt;
    int         m_exp;
    bit         m_sync;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_ir = 8'h00; m_cnt = 0; m_exp = 3; m_sync = 1'b1; m_err = 1'b0;
    endtask

    // Run one clock with the given inputs. Check outputs at negedge, then advance the model.
    task automatic cycle(input bit rst, input logic [1:0] ph, input logic [7:0] ins, input bit z);
        bit         act;
        int         op;
        logic [5:0] e;   // {ir_load, alu_en, mem_we, reg_we, pc_inc, pc_load}
        reset = rst; phase = ph; instr_in = ins; zero_in = z;
        @(negedge clk);
        act = !rst && (!CHK || (m_sync ? (int'(ph) == m_exp) : (ph == 2'd0)));
        op  = int'(m_ir[7:6]);
        e   = 6'b0;
        if (act) begin
            if (ph == 2'd0) e[5] = 1'b1;
            if (ph == 2'd2) begin e[4] = (op == 1); e[3] = (op == 2); end
            if (ph == 2'd3) begin
                e[2] = (op == 1);
                if (op == 3 && z) e[0] = 1'b1; else e[1] = 1'b1;
            end
        end
        chk("strobes", {26'd0, ir_load, alu_en, mem_we, reg_we, pc_inc, pc_load}, {26'd0, e});
        chk("ir", {24'd0, ir}, {24'd0, m_ir});
        chk("fields", {26'd0, rd, rs, rt}, {26'd0, m_ir[5:0]});
        chk("retire_cnt", {28'd0, retire_cnt}, m_cnt);
        chk("phase_err", {31'd0, phase_err}, {31'd0, m_err});
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (act && ph == 2'd0) m_ir = ins;
            if (act && ph == 2'd3) m_cnt = (m_cnt + 1) % (1 << CW);
            if (CHK) begin
                if (m_sync && int'(ph) != m_exp) begin m_sync = 1'b0; m_err = 1'b1; end
                else if (m_sync)                 m_exp = (m_exp + 1) % 4;
                else if (ph == 2'd0)             begin m_sync = 1'b1; m_exp = 1; end
            end
        end
        #1;
    endtask

    // One full legal instruction: fetch, decode, execute, store.
    task automatic instr(input logic [7:0] ins, input bit z);
        cycle(0, 2'd0, ins, 0);
        cycle(0, 2'd1, 8'h00, 0);
        cycle(0, 2'd2, 8'h00, 0);
        cycle(0, 2'd3, 8'h00, z);
    endtask

    initial begin
        reset = 1'b1; phase = 2'd3; instr_in = 8'h00; zero_in = 1'b0;
        @(posedge clk); #1;
        model_reset();
        cycle(1, 2'd3, 8'h00, 0);
        chk("reset_ir", {24'd0, ir}, 32'd0);
        chk("reset_cnt", {28'd0, retire_cnt}, 32'd0);

        // First store after reset retires a NOP, then an ALU instruction.
        cycle(0, 2'd3, 8'h00, 0);
        instr(8'h5B, 0);
        chk("alu_retire", {28'd0, retire_cnt}, 32'd2);
        chk("alu_ir", {24'd0, ir}, 32'h5B);

        // STORE, then BRZ taken and not taken.
        instr(8'h80, 0);
        instr(8'hC0, 1);
        instr(8'hC0, 0);

        // Random legal instruction stream; the 4-bit counter wraps repeatedly.
        for (int i = 0; i < 40; i++) instr(8'($urandom), 1'($urandom));

        // Explicit wrap from all-ones to zero.
        for (int i = 0; i < 16 && m_cnt != 15; i++) instr(8'h00, 0);
        chk("pre_wrap", {28'd0, retire_cnt}, 32'd15);
        instr(8'h45, 0);
        chk("wrap", {28'd0, retire_cnt}, 32'd0);

`ifdef PHASE_CHECK_EN
        // Execute directly after fetch: error, silence until next fetch, then resync.
        cycle(0, 2'd0, 8'h45, 0);
        cycle(0, 2'd2, 8'h00, 0);
        cycle(0, 2'd1, 8'h00, 0);
        cycle(0, 2'd2, 8'h00, 0);
        cycle(0, 2'd3, 8'h00, 0);
        instr(8'h5B, 0);
        chk("err_sticky", {31'd0, phase_err}, 32'd1);
        // Random phase stream, including illegal orderings.
        for (int i = 0; i < 40; i++) cycle(0, 2'($urandom), 8'($urandom), 1'($urandom));
        instr(8'h80, 0);
`endif

        // Reset during execute of an ALU instruction.
        cycle(0, 2'd0, 8'h45, 0);
        cycle(0, 2'd1, 8'h00, 0);
        cycle(1, 2'd2, 8'h00, 0);
        chk("midrst_ir", {24'd0, ir}, 32'd0);
        chk("midrst_cnt", {28'd0, retire_cnt}, 32'd0);
        chk("midrst_err", {31'd0, phase_err}, 32'd0);
        cycle(0, 2'd3, 8'h00, 0);
        instr(8'h5B, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/phase_ctrl.md
# phase_ctrl

Control-strobe generator that consumes the 2-bit phase code (fetch=00, decode=01, execute=10, store=11) emitted by the CPU phase sequencer. It latches the instruction word and decodes it. It drives per-phase datapath strobes (IR load, ALU enable, memory write, register write, PC increment/load) and counts retired instructions. An optional checker verifies that the incoming phase sequence is legal and suppresses datapath writes when it is not.

## Interface
Parameters:
- IW, 8, instruction width; fields are fixed at op=[7:6], rd=[5:4], rs=[3:2], rt=[1:0], and IW must be 8.
- CW, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- phase  in  2  current phase from the sequencer
- instr_in  in  IW  instruction word from instruction memory
- zero_in  in  1  ALU zero flag, used as the branch condition
- ir  out  IW  latched instruction register
- rd, rs, rt  out  2 each  register fields decoded from ir
- ir_load  out  1  IR capture strobe
- alu_en  out  1  ALU result-register enable
- mem_we  out  1  data-memory write
- reg_we  out  1  register-file write
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= branch target
- retire_cnt  out  CW  retired-instruction count
- phase_err  out  1  sticky illegal-sequence flag

## Operation
- Opcodes:
  - 00 NOP
  - 01 ALU (write rd)
  - 10 STORE (memory write)
  - 11 BRZ (branch if zero_in)
- Strobes are combinational from phase, ir and the internal sync bit. All strobes are 0 while reset=1 or sync=0.
- Fetch phase: ir_load=1. ir <= instr_in at the clock edge.
- Decode phase: no strobes. rd/rs/rt are always combinational slices of ir.
- Execute phase: alu_en=1 if op==01; mem_we=1 if op==10.
- Store phase:
  - reg_we=1 if op==01.
  - pc_load=1 if op==11 and zero_in=1; otherwise pc_inc=1.
  - pc_inc and pc_load are mutually exclusive.
  - retire_cnt increments by 1 and wraps modulo 2^CW (all-ones -> 0).
- Registers: ir, retire_cnt, expected-phase register exp, sync, phase_err.
- Reset values: ir=0 (NOP), retire_cnt=0, exp=11 (store), sync=1, phase_err=0. The sequencer leaves reset in store, so the first post-reset cycle is a store of a NOP. That cycle asserts pc_inc and counts one retirement.
- While in sync, exp advances each cycle: 00->01->10->11->00.
- Reset asserted mid-instruction restores all reset values on the next edge. Strobes are forced 0 in that cycle.

## Timing
- Strobes take effect in the same cycle as phase (zero latency). Datapath consumers sample them at the following clk edge.
- ir updates at the end of the fetch cycle and is valid from decode onward.
- retire_cnt updates at the end of an in-sync store cycle.
- The checker evaluates phase vs exp every cycle. A mismatch while sync=1 has these effects:
  - Strobes are suppressed in that same cycle.
  - sync <= 0 and phase_err <= 1 at the edge.
- While sync=0:
  - Fetch (00) resyncs combinationally: sync is treated as 1 in that cycle, so ir_load=1. At the edge sync <= 1 and exp <= 01.
  - Any other phase leaves all strobes 0.
- phase_err is cleared only by reset.

## Configuration
- PHASE_CHECK_EN defined: checker, sync and exp registers are present as described above.
- PHASE_CHECK_EN undefined: no checker logic. phase_err is tied to 0, sync is treated as permanently 1, and strobes depend only on phase and ir.

## Test plan
- Reset, then phase stream 11,00,01,10,11 with instr_in=8'h5B (ALU) -> pc_inc in both store cycles, ir=8'h5B after fetch, alu_en in execute, reg_we in the final store, retire_cnt=2.
- STORE instruction 8'h80 -> mem_we=1 only in execute; reg_we=0 throughout.
- BRZ 8'hC0 with zero_in=1 in store -> pc_load=1, pc_inc=0. Repeat with zero_in=0 -> pc_inc=1, pc_load=0.
- Preload retire_cnt to all-ones by forcing CW=4 and running 15 instructions -> the 16th store wraps retire_cnt to 0.
- With PHASE_CHECK_EN: inject phase 10 directly after fetch -> phase_err=1 and all strobes 0 until the next 00. On that fetch ir_load=1, and the next store yields pc_inc=1. phase_err stays 1 until reset.
- Assert reset during execute of an ALU instruction -> alu_en=0 that cycle. Next cycle ir=0, retire_cnt=0, phase_err=0.
